// File: rtl/register_bank_dump_if.sv
// Connection bundle between the dump engine, the register bank read port and the debug TX stream.
interface register_bank_dump_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_BYTE     = 8
);
    logic                   i_start;
    logic [NB_REGISTER-1:0] o_read_reg_sel;
    logic [NB_DATA-1:0]     i_data_read_reg;
    logic [NB_BYTE-1:0]     o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        input  i_start,
        input  i_data_read_reg,
        input  i_tx_ready,
        output o_read_reg_sel,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_data_read_reg,
        output i_tx_ready,
        input  o_read_reg_sel,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/register_bank_dump.sv
// Walks every GPR through one bank read port and streams each word MSB-first as bytes
// on a valid/ready interface toward the debug UART.
module register_bank_dump #(
    parameter int NB_DATA     = 32,
    parameter int N_REGISTERS = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_BYTE     = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    register_bank_dump_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [NB_REGISTER-1:0] reg_idx;
    logic [1:0]             byte_cnt;
    logic [NB_DATA-1:0]     shift;
    logic                   last_byte;
    logic                   last_reg;

    assign last_byte = (byte_cnt == 2'd3);
    assign last_reg  = (reg_idx == NB_REGISTER'(N_REGISTERS - 1));

    assign bus.o_read_reg_sel = reg_idx;
    assign bus.o_tx_data      = shift[NB_DATA-1 -: NB_BYTE];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            reg_idx  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    reg_idx  <= '0;
                    byte_cnt <= '0;
                end
                CAPTURE: begin
                    shift    <= bus.i_data_read_reg;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (bus.i_tx_ready) begin
                        shift    <= {shift[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                        byte_cnt <= byte_cnt + 2'd1;
                        // reg_idx holds at the last register so the select never wraps
                        if (last_byte && !last_reg) begin
                            reg_idx <= reg_idx + NB_REGISTER'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from the state register only, so valid never follows ready combinationally.
    always_comb begin
        next_state     = state;
        bus.o_tx_valid = 1'b0;
        bus.o_busy     = 1'b1;
        bus.o_done     = 1'b0;
        case (state)
            IDLE: begin
                bus.o_busy = 1'b0;
                if (bus.i_start) begin
                    next_state = SELECT;
                end
            end
            SELECT:  next_state = CAPTURE;
            CAPTURE: next_state = SEND;
            SEND: begin
                bus.o_tx_valid = 1'b1;
                if (bus.i_tx_ready && last_byte) begin
                    next_state = last_reg ? DONE : SELECT;
                end
            end
            DONE: begin
                bus.o_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_register_bank_dump.sv
// Randomized bench for register_bank_dump: a byte-queue model built from the bank contents
// is compared against the stream on every transfer, plus directed timing and reset checks.
module tb_register_bank_dump;
    logic clk;
    logic rst;

    register_bank_dump_if #(.NB_DATA(32), .NB_REGISTER(5), .NB_BYTE(8)) bus ();

    register_bank_dump #(
        .NB_DATA(32),
        .N_REGISTERS(32),
        .NB_REGISTER(5),
        .NB_BYTE(8)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          passes;
    logic [7:0]  expq[$];
    int          nbytes;
    int          done_cnt;
    bit          mon_en;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic [31:0] bank[32];
    logic [31:0] bank_q;
    bit          reg_mode;

    // Bank model: combinational read, or one cycle of read latency when reg_mode is set.
    always @(posedge clk) bank_q <= bank[bus.o_read_reg_sel];
    assign bus.i_data_read_reg = reg_mode ? bank_q : bank[bus.o_read_reg_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic build_queue();
        logic [31:0] w;
        expq.delete();
        for (int i = 0; i < 32; i++) begin
            w = bank[i];
            for (int b = 3; b >= 0; b--) expq.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 32; i++) bank[i] = (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i));
    endtask

    task automatic load_random();
        bank[0] = 32'h0;
        for (int i = 1; i < 32; i++) bank[i] = $urandom;
    endtask

    // Stream monitor: every accepted byte must be the next one the model expects.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                chk("hold_data", 32'(bus.o_tx_data), 32'(prev_data));
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (expq.size() == 0) chk("extra_byte", 32'(nbytes + 1), 32'd128);
                else chk($sformatf("byte%0d", nbytes), 32'(bus.o_tx_data), 32'(expq.pop_front()));
                nbytes++;
            end
            if (bus.o_done) begin
                done_cnt++;
                chk("done_after_last", 32'(expq.size()), 32'd0);
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_sel"},   32'(bus.o_read_reg_sel), 32'd0);
        chk({tag, "_data"},  32'(bus.o_tx_data),      32'd0);
        chk({tag, "_valid"}, 32'(bus.o_tx_valid),     32'd0);
        chk({tag, "_busy"},  32'(bus.o_busy),         32'd0);
        chk({tag, "_done"},  32'(bus.o_done),         32'd0);
    endtask

    task automatic begin_dump();
        build_queue();
        nbytes     = 0;
        done_cnt   = 0;
        prev_stall = 0;
        mon_en     = 1;
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        chk("busy_at_E0", 32'(bus.o_busy), 32'd1);
        chk("sel_at_E0", 32'(bus.o_read_reg_sel), 32'd0);
        chk("valid_at_E0", 32'(bus.o_tx_valid), 32'd0);
    endtask

    task automatic run_dump(input int pct, input bit busy_starts, input bit check_timing);
        int cyc;
        int done_at;
        bit s10;
        bit s127;
        bus.i_tx_ready = (pct >= 100);
        begin_dump();
        cyc = 0;
        done_at = -1;
        s10 = 0;
        s127 = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            bus.i_tx_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            bus.i_start = 1'b0;
            if (busy_starts && nbytes >= 10 && !s10) begin bus.i_start = 1'b1; s10 = 1; end
            if (busy_starts && nbytes >= 127 && !s127) begin bus.i_start = 1'b1; s127 = 1; end
            @(posedge clk); #1;
            cyc++;
            if (check_timing && cyc == 1) chk("capture_no_valid", 32'(bus.o_tx_valid), 32'd0);
            if (check_timing && cyc == 2) chk("first_valid_E2", 32'(bus.o_tx_valid), 32'd1);
            if (bus.o_done && done_at < 0) done_at = cyc;
        end
        bus.i_start = 1'b0;
        chk("dump_finished", 32'(done_cnt), 32'd1);
        if (check_timing) chk("done_edge", 32'(done_at), 32'd192);
        chk("byte_total", 32'(nbytes), 32'd128);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);
        chk("idle_done", 32'(bus.o_done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt), 32'd1);
        chk("still_idle", 32'(bus.o_busy), 32'd0);
        mon_en = 0;
        bus.i_tx_ready = 1'b0;
    endtask

    initial begin
        int guard;
        checks = 0;
        passes = 0;
        mon_en = 0;
        prev_stall = 0;
        reg_mode = 0;
        nbytes = 0;
        done_cnt = 0;
        bus.i_start = 1'b0;
        bus.i_tx_ready = 1'b0;
        load_pattern();
        rst = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check_outputs_zero("idle");
        end

        build_queue();
        chk("model_len", 32'(expq.size()), 32'd128);
        chk("model_b0", 32'(expq[0]), 32'h00);
        chk("model_b4", 32'(expq[4]), 32'hA5);
        chk("model_b7", 32'(expq[7]), 32'h01);
        chk("model_last", 32'(expq[127]), 32'h1F);

        run_dump(100, 0, 1);

        load_random();
        run_dump(30, 0, 0);

        load_pattern();
        run_dump(100, 1, 1);

        // Abort mid-stream with reset, then restart from register 0.
        bus.i_tx_ready = 1'b1;
        begin_dump();
        guard = 0;
        while (nbytes < 50 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reached_byte50", 32'(nbytes), 32'd50);
        mon_en = 0;
        rst = 1'b1;
        bus.i_tx_ready = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        chk("no_done_mid", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        run_dump(100, 0, 1);

        reg_mode = 1;
        load_pattern();
        run_dump(100, 0, 1);
        load_random();
        run_dump(50, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/register_bank_dump.md
# register_bank_dump

Debug-side reader for `register_bank`. On a start pulse it walks all 32 GPRs through one read port of the bank, captures each 32-bit word and emits it as four bytes, MSB first, on a valid/ready byte stream that feeds the debug unit's UART transmitter. It sits between the register bank's second read port (muxed in while the pipeline is halted) and the debug TX path. It drives `o_busy` so the debug unit holds the read-port mux and the pipeline halt for the whole dump.

## Interface
- `NB_DATA`, 32, register width
- `N_REGISTERS`, 32, registers dumped (indices 0..N_REGISTERS-1)
- `NB_REGISTER`, 5, register select width
- `NB_BYTE`, 8, stream byte width
- `i_clock`  in  1  single clock, all state updates on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  dump request; sampled only in IDLE
- `o_read_reg_sel`  out  NB_REGISTER  select to bank read port (`i_read_reg_sel_1`)
- `i_data_read_reg`  in  NB_DATA  data from bank read port (`o_data_read_reg_1`)
- `o_tx_data`  out  NB_BYTE  stream byte
- `o_tx_valid`  out  1  byte valid
- `i_tx_ready`  in  1  consumer accepts byte when high with `o_tx_valid`
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse after the last byte is accepted

## Operation
- Internal state: `reg_idx` (NB_REGISTER), `byte_cnt` (2 bits), `shift` (NB_DATA), FSM.
- `o_read_reg_sel` = `reg_idx`, registered.
- `o_tx_data` = `shift[NB_DATA-1 -: NB_BYTE]`.
- FSM states:
  - IDLE: `reg_idx`=0, `byte_cnt`=0. On `i_start`=1, go to SELECT.
  - SELECT: one wait cycle so a combinational or 1-cycle registered bank read settles. Go to CAPTURE.
  - CAPTURE: at the end of this cycle, `shift` <= `i_data_read_reg` and `byte_cnt` <= 0. Go to SEND.
  - SEND: `o_tx_valid`=1. On `i_tx_ready`=1:
    - shift `shift` left by NB_BYTE and increment `byte_cnt`.
    - If `byte_cnt` was 3 and `reg_idx`=N_REGISTERS-1, go to DONE.
    - If `byte_cnt` was 3 otherwise, `reg_idx`++ and go to SELECT.
    - Otherwise stay in SEND.
  - DONE: `o_done`=1 for this cycle only. Go to IDLE.
- Register 0 is dumped like any other; it reads 0 from the bank.
- `i_start` outside IDLE is ignored; no queuing.
- `i_start` held high: a new dump starts on the first cycle back in IDLE.
- Byte order per register is bits [31:24], [23:16], [15:8], [7:0]. Registers go in ascending index order. Total stream is 128 bytes.
- `reg_idx` never wraps; the dump ends at N_REGISTERS-1.

## Timing
- Reset values:
  - `o_read_reg_sel`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_busy`=0, `o_done`=0
  - FSM=IDLE, `shift`=0
- Reset mid-dump aborts on the next edge: outputs return to reset values, no `o_done` pulse, and the partial stream is not resumed.
- `i_start` sampled at edge E0 gives `o_busy`=1 and `o_read_reg_sel`=0 from E0.
- The first `o_tx_valid` is asserted from E2.
- Data is sampled at the edge ending CAPTURE, two edges after `o_read_reg_sel` updates.
- Valid/ready rules:
  - `o_tx_valid` never drops and `o_tx_data` never changes until the byte is accepted.
  - `o_tx_valid` does not depend combinationally on `i_tx_ready`.
  - A byte transfers on every edge where both are high.
- With `i_tx_ready` tied high, each register takes 6 cycles (SELECT, CAPTURE, 4×SEND). The last byte is accepted at E192.
- With `i_tx_ready` tied high, `o_done` is high during E192..E193, then IDLE with `o_busy`=0 from E193.
- `o_tx_valid` is 0 in SELECT, CAPTURE, DONE and IDLE, which gives a 2-cycle bubble between registers.

## Test plan
- Reset then idle: hold `i_reset` 5 cycles, `i_start`=0 for 20 cycles -> all outputs 0, `o_busy`=0, no `o_tx_valid`.
- Full dump, ready tied high:
  - Stimulus: bank model loaded with reg[i] = 32'hA5000000 | i (reg0 = 0), one `i_start` pulse.
  - Response: 128 bytes in order 00,00,00,00, A5,00,00,01, … A5,00,00,1F.
  - Response: `o_done` single pulse one cycle after the 128th byte, at E192.
- Backpressure:
  - Stimulus: `i_tx_ready` random 30% high, random bank contents.
  - Response: same 128-byte stream; `o_tx_data` stable while `o_tx_valid`=1 and `i_tx_ready`=0.
  - Response: byte count is exactly 128 and no byte is duplicated.
- Start while busy: pulse `i_start` again at bytes 10 and 127 -> stream unchanged, exactly one `o_done`, then IDLE.
- Reset mid-dump: assert `i_reset` after byte 50 -> next cycle all outputs 0, no `o_done`. A new `i_start` restarts from reg 0, byte 0x00 of 32'h00000000.
- Registered-read bank model (1-cycle read latency) with the full-dump stimulus -> identical 128-byte stream, confirming SELECT/CAPTURE spacing.
